ppu_sprite_line: RTL
====================

Name: ppu_sprite_line

Overview:
Parametrised per-scanline sprite engine for the PPU. It replaces the flat all-sprites-every-pixel compare with two steps. First, an OAM scan builds a list of at most LINE_MAX sprites visible on the current line. Second, a per-pixel lookup over that list returns the winning sprite's tile-row address, column, palette and priority. The block adds 8x16 sprites, the per-line sprite limit, and X-then-index priority. It sits between the OAM memory-map port and the sprite tile RAM.

Parameters:
SPRITE_COUNT, 40, number of OAM entries (4 bytes each: Y, X, tile, attr)
LINE_MAX, 10, maximum sprites kept per scanline
IDX_W, 6, width of OAM index; must satisfy 2^IDX_W >= SPRITE_COUNT

Ports:
clockgb  in  1  PPU clock
resetn  in  1  asynchronous active-low reset
oam_we  in  1  OAM byte write strobe
oam_addr  in  8  OAM byte address (read and write)
oam_wdata  in  8  OAM write data
oam_rdata  out  8  combinational read of oam_addr; 0 if address >= 4*SPRITE_COUNT
start  in  1  one-cycle pulse at mode-2 entry
line  in  8  current LY, sampled on start
tall  in  1  LCDC bit 2 (8x16 sprites), sampled on start
enable  in  1  LCDC bit 1; gates hit
busy  out  1  scan in progress
done  out  1  one-cycle pulse when the list is final
count  out  4  sprites in the list (0..LINE_MAX)
px_valid  in  1  pixel query strobe
px  in  8  screen X of query
hit  out  1  a listed sprite covers px (registered)
tile_row  out  12  tram row address of the winner
col  out  3  bit index into hi/lo bytes after X flip (7 = leftmost)
pal  out  1  attr bit 4
pri  out  1  attr bit 7 (1 = behind non-zero BG)

Behaviour:
- Reset values: OAM bytes 0; busy, done, hit, count, tile_row, col, pal, pri all 0; FSM in IDLE.
- OAM write: on the clock edge when oam_we and oam_addr < 4*SPRITE_COUNT. Out-of-range writes are ignored.
- FSM states: IDLE -> SCAN on start. SCAN -> DONE after entry SPRITE_COUNT-1. DONE -> IDLE next cycle.
  - done is high only in DONE.
  - busy is high only in SCAN.
  - Start-to-done latency is SPRITE_COUNT+1 cycles.
- Scan order: SCAN examines entry i in scan cycle i, in ascending index order.
- Visibility test: d = {0,line} + 16 - {0,Y}, computed 9-bit. The sprite is visible iff d < (tall ? 16 : 8), as an unsigned compare, so negative values wrap large and fail.
- List capture: a visible entry is appended (index, d[3:0]) while count < LINE_MAX. Later visible entries are dropped. X is not part of the visibility test; off-screen X still consumes a slot.
- start in any state clears count to 0 and restarts the scan at entry 0, latching line and tall.
- OAM writes during SCAN take effect for entries not yet examined.
- Lookup:
  - On px_valid with busy=0 and enable=1, each list slot k is tested: e = {0,px} + 8 - {0,X}, 9-bit; the slot covers px iff e < 8.
  - Winner: smallest X. Ties go to the lowest list position, i.e. the lowest OAM index.
  - Outputs appear the cycle after px_valid (1-cycle latency).
  - No transparency fallthrough: the winner is purely geometric.
- Row and address:
  - row = d[3:0]. If attr bit 6 (Y flip) is set, row = (tall ? 15 : 7) - row.
  - tile_row = tall ? {1'b0, tile[7:1], row[3:0]} : {1'b0, tile, row[2:0]}.
- Column: col = 7 - e[2:0]. If attr bit 5 (X flip) is set, col = e[2:0].
- Lookup gating:
  - If px_valid is 0, busy is 1, or enable is 0, hit goes to 0 next cycle and the other lookup outputs hold their values.
  - X and attr are read live from OAM at lookup time; the list stores only index and row.
- Asynchronous reset mid-scan returns to IDLE with count 0.

Test Plan:
- Reset, then write OAM entry 0 as Y=16, X=8, tile=0x12, attr=0. Pulse start with line=0, tall=0 -> done exactly 41 cycles later with count=1. Query px=0 -> next cycle hit=1, tile_row=0x090, col=7, pal=0.
- 12 entries all with Y=20 and X=8*i+8, line=4 -> count=10. Query at the X of entry 11 -> hit=0. Query at the X of entry 9 -> hit=1.
- tall=1, entry Y=16, tile=0x13, attr=0x40 (Y flip), line=3 -> tile_row = {0, 0x09, 4'd12} = 0x09C. Same with tall=0 -> the entry is visible and row=4.
- Entries 0 (X=20) and 1 (X=16) overlapping at px=13 -> entry 1 wins. Set both X=16 -> entry 0 wins. Set X flip on the winner at px=8 -> col=0.
- Pulse start again 15 cycles into a scan -> done at 41 cycles after the second pulse, and the list reflects an OAM write made to entry 30 before it was examined.
- Assert resetn low mid-scan -> busy=0, count=0, hit=0 immediately. enable=0 with a covering sprite -> hit=0.

Source files
------------

// File: rtl/ppu_sprite_line.sv
// Per-scanline sprite engine: an OAM scan builds a list of up to LINE_MAX visible
// sprites, then a per-pixel lookup over that list picks the winning sprite.
module ppu_sprite_line #(
  parameter int SPRITE_COUNT = 40,
  parameter int LINE_MAX     = 10,
  parameter int IDX_W        = 6
) (
  input  logic        clockgb,
  input  logic        resetn,
  input  logic        oam_we,
  input  logic [7:0]  oam_addr,
  input  logic [7:0]  oam_wdata,
  output logic [7:0]  oam_rdata,
  input  logic        start,
  input  logic [7:0]  line,
  input  logic        tall,
  input  logic        enable,
  output logic        busy,
  output logic        done,
  output logic [3:0]  count,
  input  logic        px_valid,
  input  logic [7:0]  px,
  output logic        hit,
  output logic [11:0] tile_row,
  output logic [2:0]  col,
  output logic        pal,
  output logic        pri
);

  localparam int              OAM_BYTES  = 4 * SPRITE_COUNT;
  localparam logic [8:0]      OAM_LIMIT  = 9'(OAM_BYTES);
  localparam logic [3:0]      LIST_LIMIT = 4'(LINE_MAX);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SPRITE_COUNT - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  function automatic logic [7:0] byte_addr(input logic [IDX_W-1:0] idx, input logic [1:0] fld);
    return 8'({idx, fld});
  endfunction

  // Vertical flip mirrors the row within an 8- or 16-line sprite.
  function automatic logic [3:0] flip_row(input logic [3:0] row, input logic yflip,
                                          input logic is_tall);
    logic [3:0] top;
    top = is_tall ? 4'd15 : 4'd7;
    return yflip ? (top - row) : row;
  endfunction

  // col 7 selects the leftmost pixel of the tile byte pair.
  function automatic logic [2:0] pick_col(input logic [2:0] e, input logic xflip);
    return xflip ? e : (3'd7 - e);
  endfunction

  logic [7:0]       oam_q [0:OAM_BYTES-1];
  logic [7:0]       oam_d [0:OAM_BYTES-1];
  state_t           state_q, state_d;
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic [3:0]       count_q, count_d;
  logic [7:0]       line_q, line_d;
  logic             tall_q, tall_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] list_idx_q [0:LINE_MAX-1];
  logic [IDX_W-1:0] list_idx_d [0:LINE_MAX-1];
  logic [3:0]       list_row_q [0:LINE_MAX-1];
  logic [3:0]       list_row_d [0:LINE_MAX-1];
  logic             hit_q, hit_d;
  logic [11:0]      tile_row_q, tile_row_d;
  logic [2:0]       col_q, col_d;
  logic             pal_q, pal_d;
  logic             pri_q, pri_d;

  logic [7:0]       scan_y;
  logic [8:0]       scan_dy;
  logic             scan_vis;

  logic             found;
  logic [7:0]       best_x;
  logic [IDX_W-1:0] best_idx;
  logic [3:0]       best_row;
  logic [2:0]       best_e;
  logic [7:0]       cand_x;
  logic [8:0]       cand_e;
  logic [7:0]       best_tile;
  logic [3:0]       row_f;
  logic             query;

  always_comb begin
    oam_rdata = 8'h00;
    if ({1'b0, oam_addr} < OAM_LIMIT) oam_rdata = oam_q[oam_addr];
  end

  always_comb begin
    for (int i = 0; i < OAM_BYTES; i++) oam_d[i] = oam_q[i];
    if (oam_we && ({1'b0, oam_addr} < OAM_LIMIT)) oam_d[oam_addr] = oam_wdata;
  end

  // Visibility uses a 9-bit difference so sprites above the line wrap large and fail.
  always_comb begin
    scan_y   = oam_q[byte_addr(scan_idx_q, 2'd0)];
    scan_dy  = {1'b0, line_q} + 9'd16 - {1'b0, scan_y};
    scan_vis = scan_dy < (tall_q ? 9'd16 : 9'd8);
  end

  always_comb begin
    state_d    = state_q;
    scan_idx_d = scan_idx_q;
    count_d    = count_q;
    line_d     = line_q;
    tall_d     = tall_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    for (int k = 0; k < LINE_MAX; k++) begin
      list_idx_d[k] = list_idx_q[k];
      list_row_d[k] = list_row_q[k];
    end
    if (start) begin
      state_d    = SCAN;
      scan_idx_d = '0;
      count_d    = 4'd0;
      line_d     = line;
      tall_d     = tall;
      busy_d     = 1'b1;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        SCAN: begin
          if (scan_vis && (count_q < LIST_LIMIT)) begin
            list_idx_d[count_q] = scan_idx_q;
            list_row_d[count_q] = scan_dy[3:0];
            count_d             = count_q + 4'd1;
          end
          if (scan_idx_q == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            scan_idx_d = scan_idx_q + 1'b1;
            busy_d     = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Strict less-than keeps the earliest list slot on equal X, i.e. the lowest OAM index.
  always_comb begin
    found    = 1'b0;
    best_x   = 8'd0;
    best_idx = '0;
    best_row = 4'd0;
    best_e   = 3'd0;
    cand_x   = 8'd0;
    cand_e   = 9'd0;
    for (int k = 0; k < LINE_MAX; k++) begin
      cand_x = oam_q[byte_addr(list_idx_q[k], 2'd1)];
      cand_e = {1'b0, px} + 9'd8 - {1'b0, cand_x};
      if ((4'(k) < count_q) && (cand_e < 9'd8) && (!found || (cand_x < best_x))) begin
        found    = 1'b1;
        best_x   = cand_x;
        best_idx = list_idx_q[k];
        best_row = list_row_q[k];
        best_e   = cand_e[2:0];
      end
    end
  end

  always_comb begin
    query      = px_valid && !busy_q && enable;
    best_tile  = oam_q[byte_addr(best_idx, 2'd2)];
    row_f      = flip_row(best_row, oam_q[byte_addr(best_idx, 2'd3)][6], tall_q);
    hit_d      = query && found;
    tile_row_d = tile_row_q;
    col_d      = col_q;
    pal_d      = pal_q;
    pri_d      = pri_q;
    if (query && found) begin
      tile_row_d = tall_q ? {1'b0, best_tile[7:1], row_f} : {1'b0, best_tile, row_f[2:0]};
      col_d      = pick_col(best_e, oam_q[byte_addr(best_idx, 2'd3)][5]);
      pal_d      = oam_q[byte_addr(best_idx, 2'd3)][4];
      pri_d      = oam_q[byte_addr(best_idx, 2'd3)][7];
    end
  end

  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < OAM_BYTES; i++) oam_q[i] <= 8'h00;
      for (int k = 0; k < LINE_MAX; k++) begin
        list_idx_q[k] <= '0;
        list_row_q[k] <= 4'd0;
      end
      state_q    <= IDLE;
      scan_idx_q <= '0;
      count_q    <= 4'd0;
      line_q     <= 8'd0;
      tall_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      tile_row_q <= 12'd0;
      col_q      <= 3'd0;
      pal_q      <= 1'b0;
      pri_q      <= 1'b0;
    end else begin
      for (int i = 0; i < OAM_BYTES; i++) oam_q[i] <= oam_d[i];
      for (int k = 0; k < LINE_MAX; k++) begin
        list_idx_q[k] <= list_idx_d[k];
        list_row_q[k] <= list_row_d[k];
      end
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
      count_q    <= count_d;
      line_q     <= line_d;
      tall_q     <= tall_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hit_q      <= hit_d;
      tile_row_q <= tile_row_d;
      col_q      <= col_d;
      pal_q      <= pal_d;
      pri_q      <= pri_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign hit      = hit_q;
  assign tile_row = tile_row_q;
  assign col      = col_q;
  assign pal      = pal_q;
  assign pri      = pri_q;

endmodule
